// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main-memory block port: the I-cache (read-only)
// and the D-cache (read/write) take turns, one block transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   I_READ,
    input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] I_READDATA,
    output logic                   I_BUSYWAIT,
    input  logic                   D_READ,
    input  logic                   D_WRITE,
    input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] D_READDATA,
    output logic                   D_BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GRANT_I = 3'd1;
    localparam logic [2:0] GRANT_D = 3'd2;
    localparam logic [2:0] DONE_I  = 3'd3;
    localparam logic [2:0] DONE_D  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   issued_q, issued_d;
    logic                   last_d_q, last_d_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BLOCK_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req = I_READ;
    assign d_req = D_READ | D_WRITE;

    // On contention the side not served last wins; last_d_q resets low so D takes the first tie.
    assign grant_d = d_req & (~i_req | ~last_d_q);
    assign grant_i = i_req & ~grant_d;

    // NOTE: every next-state value starts from its current value, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        last_d_d    = last_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = GRANT_D;
                    mem_addr_d  = D_ADDRESS;
                    mem_wdata_d = D_WRITEDATA;
                    // A simultaneous read and write is treated as the write.
                    mem_write_d = D_WRITE;
                    mem_read_d  = ~D_WRITE;
                end else if (grant_i) begin
                    state_d     = GRANT_I;
                    mem_addr_d  = I_ADDRESS;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                // The first grant cycle only issues; memory busy is not trusted until then.
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (!MEM_BUSYWAIT) begin
                    state_d     = (state_q == GRANT_I) ? DONE_I : DONE_D;
                    issued_d    = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    last_d_d    = (state_q == GRANT_D);
                    if (mem_read_q) begin
                        if (state_q == GRANT_I) i_rdata_d = MEM_READDATA;
                        else                    d_rdata_d = MEM_READDATA;
                    end
                end
            end
            DONE_I, DONE_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others; the data registers are plain flops and reset with them.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            issued_q    <= 1'b0;
            last_d_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            last_d_q    <= last_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Stalls are released only during the requester's single DONE cycle.
    assign I_BUSYWAIT    = I_READ & (state_q != DONE_I);
    assign D_BUSYWAIT    = d_req & (state_q != DONE_D);
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign I_READDATA    = i_rdata_q;
    assign D_READDATA    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: arbitration table, directed multi-cycle sequences and a
// randomized two-agent run checked against a transaction-level memory/fairness model.
module tb_mem_port_arbiter;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         I_READ;
    logic [27:0]  I_ADDRESS;
    logic [127:0] I_READDATA;
    logic         I_BUSYWAIT;
    logic         D_READ;
    logic         D_WRITE;
    logic [27:0]  D_ADDRESS;
    logic [127:0] D_WRITEDATA;
    logic [127:0] D_READDATA;
    logic         D_BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_WIDTH(28), .BLOCK_WIDTH(128)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Power-on content of main memory; one block carries the documented test pattern.
    function automatic logic [127:0] init_val(input logic [27:0] a);
        if (a == 28'h0000010) return 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F;
        return {a, 4'h5, ~a, 4'hA, a ^ 28'h5A5A5A5, 4'h3, a[13:0], a[27:14], 4'hC};
    endfunction

    // Main-memory model: busy for cur_lat cycles counted from the first strobe cycle.
    int  strobe_cnt = 0;
    int  cur_lat    = 0;
    int  lat_cfg    = 0;
    bit  rand_lat   = 1'b0;
    logic [127:0] mem_store [bit [27:0]];

    always @(negedge CLK) begin
        if (MEM_READ || MEM_WRITE) strobe_cnt = strobe_cnt + 1;
        else                       strobe_cnt = 0;
        if (strobe_cnt == 1) cur_lat = rand_lat ? int'($urandom_range(0, 4)) : lat_cfg;
        MEM_BUSYWAIT = (strobe_cnt >= 1) && (strobe_cnt <= cur_lat);
        if (MEM_WRITE) mem_store[MEM_ADDRESS] = MEM_WRITEDATA;
        MEM_READDATA = mem_store.exists(MEM_ADDRESS) ? mem_store[MEM_ADDRESS] : init_val(MEM_ADDRESS);
    end

    // Reference view of memory as seen by completed transactions.
    logic [127:0] ref_mem [bit [27:0]];

    function automatic logic [127:0] model_read(input logic [27:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Waits until either requester sees its DONE cycle (bounded).
    task automatic wait_any(output int cyc, output bit i_fin, output bit d_fin);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            i_fin = I_READ && !I_BUSYWAIT;
            d_fin = (D_READ || D_WRITE) && !D_BUSYWAIT;
        end while (!i_fin && !d_fin && cyc < 60);
        check("completion_within_budget", (i_fin || d_fin), 1'b1);
    endtask

    // One isolated transaction; checks DONE timing, strobe length and read data.
    task automatic run_single(input bit is_i, input bit is_wr, input logic [27:0] addr,
                              input logic [127:0] wdata, input int exp_cyc);
        int cyc = 0;
        int strobe = 0;
        bit busy;
        if (is_i) begin
            I_ADDRESS = addr; I_READ = 1'b1;
        end else begin
            D_ADDRESS = addr; D_WRITEDATA = wdata; D_WRITE = is_wr; D_READ = !is_wr;
        end
        do begin
            @(negedge CLK);
            cyc++;
            if (MEM_READ || MEM_WRITE) strobe++;
            busy = is_i ? I_BUSYWAIT : D_BUSYWAIT;
        end while (busy && cyc < 60);
        check("single_done_cycle", cyc, exp_cyc);
        check("single_strobe_cycles", strobe, exp_cyc - 1);
        if (is_i)        check("single_i_data", I_READDATA, model_read(addr));
        else if (!is_wr) check("single_d_data", D_READDATA, model_read(addr));
        else             ref_mem[addr] = wdata;
        I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    endtask

    typedef struct {
        bit [1:0]    prior;     // 0 none, 1 I served last, 2 D served last
        bit          i_rd;
        bit          d_rd;
        bit          d_wr;
        bit          exp_rd;
        bit          exp_wr;
        logic [27:0] exp_addr;
    } arb_vec_t;

    localparam logic [27:0] IA = 28'h1000AAA;
    localparam logic [27:0] DA = 28'h0400BBB;

    arb_vec_t vec [10];

    // Random-agent helpers
    task automatic new_d_req();
        int op;
        op = int'($urandom_range(0, 7));
        D_ADDRESS   = 28'h0200000 + 28'($urandom_range(0, 3));
        D_WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
        D_READ      = (op < 4) || (op == 7);
        D_WRITE     = (op >= 4);
    endtask

    initial begin
        int  cyc, cyc2, rd_cnt, bad;
        bit  i_fin, d_fin, d_busy_seen, i_low_seen;
        logic [127:0] d_before;

        RESET = 1'b0; I_READ = 1'b0; I_ADDRESS = '0;
        D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_mem_write", MEM_WRITE, 1'b0);
        check("rst_mem_addr", MEM_ADDRESS, 28'h0);
        check("rst_mem_wdata", MEM_WRITEDATA, 128'h0);
        check("rst_i_rdata", I_READDATA, 128'h0);
        check("rst_d_rdata", D_READDATA, 128'h0);
        check("rst_i_busy", I_BUSYWAIT, 1'b0);
        check("rst_d_busy", D_BUSYWAIT, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);

        // Single I read, memory busy 5 cycles
        lat_cfg = 5; I_ADDRESS = 28'h0000010; I_READ = 1'b1;
        #1 check("i_busy_same_cycle", I_BUSYWAIT, 1'b1);
        cyc = 0; rd_cnt = 0; d_busy_seen = 1'b0;
        do begin
            @(negedge CLK);
            cyc++;
            if (MEM_READ) rd_cnt++;
            if (D_BUSYWAIT) d_busy_seen = 1'b1;
        end while (I_BUSYWAIT && cyc < 60);
        check("i_read_done_cycle", cyc, 7);
        check("i_read_strobe_cycles", rd_cnt, 6);
        check("i_read_data", I_READDATA, 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F);
        check("i_read_no_d_busy", d_busy_seen, 1'b0);
        I_READ = 1'b0;
        @(negedge CLK);
        check("i_read_data_held", I_READDATA, 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F);

        // D write-back, memory busy 3 cycles
        lat_cfg = 3; d_before = D_READDATA;
        D_ADDRESS = 28'h0ABCDEF; D_WRITEDATA = 128'h1; D_WRITE = 1'b1;
        cyc = 0; bad = 0;
        do begin
            @(negedge CLK);
            cyc++;
            if (D_BUSYWAIT && !(MEM_WRITE && !MEM_READ && MEM_ADDRESS == 28'h0ABCDEF &&
                                MEM_WRITEDATA == 128'h1)) bad++;
        end while (D_BUSYWAIT && cyc < 60);
        check("d_write_done_cycle", cyc, 5);
        check("d_write_port_stable", bad, 0);
        check("d_write_rdata_unchanged", D_READDATA, d_before);
        check("d_write_strobe_low_in_done", MEM_WRITE, 1'b0);
        ref_mem[28'h0ABCDEF] = 128'h1;
        D_WRITE = 1'b0;
        @(negedge CLK);

        // Zero-latency memory: 2 grant cycles plus DONE
        lat_cfg = 0;
        run_single(1'b1, 1'b0, 28'h1000123, '0, 3);
        @(negedge CLK);
        run_single(1'b0, 1'b1, 28'h0300010, 128'hCAFE, 3);
        @(negedge CLK);
        run_single(1'b0, 1'b0, 28'h0300010, '0, 3);
        @(negedge CLK);

        // Arbitration table: one grant edge after the request
        vec[0] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, IA};
        vec[1] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, DA};
        vec[2] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DA};
        vec[3] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, DA};
        vec[4] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DA};
        vec[5] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, IA};
        vec[6] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DA};
        vec[7] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, DA};
        vec[8] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0};
        vec[9] = '{2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, IA};
        for (int k = 0; k < 10; k++) begin
            do_reset();
            lat_cfg = 0;
            if (vec[k].prior == 2'd1) begin
                run_single(1'b1, 1'b0, 28'h1000100, '0, 3);
                @(negedge CLK);
            end else if (vec[k].prior == 2'd2) begin
                run_single(1'b0, 1'b1, 28'h0300000, 128'h77, 3);
                @(negedge CLK);
            end
            I_ADDRESS = IA; D_ADDRESS = DA; D_WRITEDATA = 128'h5555;
            I_READ = vec[k].i_rd; D_READ = vec[k].d_rd; D_WRITE = vec[k].d_wr;
            #1;
            check($sformatf("tbl%0d_i_busy", k), I_BUSYWAIT, vec[k].i_rd);
            check($sformatf("tbl%0d_d_busy", k), D_BUSYWAIT, vec[k].d_rd | vec[k].d_wr);
            @(negedge CLK);
            check($sformatf("tbl%0d_mem_read", k), MEM_READ, vec[k].exp_rd);
            check($sformatf("tbl%0d_mem_write", k), MEM_WRITE, vec[k].exp_wr);
            check($sformatf("tbl%0d_mem_addr", k), MEM_ADDRESS, vec[k].exp_addr);
            I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        end

        // Contention straight out of reset: D first, I stalled throughout
        do_reset();
        lat_cfg = 1;
        I_ADDRESS = 28'h1000001; D_ADDRESS = 28'h0500003;
        I_READ = 1'b1; D_READ = 1'b1;
        cyc = 0; i_low_seen = 1'b0;
        do begin
            @(negedge CLK);
            cyc++;
            if (!I_BUSYWAIT) i_low_seen = 1'b1;
        end while (D_BUSYWAIT && cyc < 60);
        check("cont_d_first_cycle", cyc, 3);
        check("cont_i_stalled", i_low_seen, 1'b0);
        check("cont_d_data", D_READDATA, model_read(28'h0500003));
        D_READ = 1'b0;
        wait_any(cyc, i_fin, d_fin);
        check("cont_i_second", i_fin, 1'b1);
        check("cont_i_cycle", cyc, 4);
        check("cont_i_data", I_READDATA, model_read(28'h1000001));

        // Fairness: D keeps requesting after its DONE while I waits
        @(negedge CLK);
        lat_cfg = 0;
        I_ADDRESS = 28'h1000002; D_ADDRESS = 28'h0500004;
        I_READ = 1'b1; D_READ = 1'b1;
        wait_any(cyc, i_fin, d_fin);
        check("fair_d_first", {i_fin, d_fin}, 2'b01);
        D_ADDRESS = 28'h0500005;
        wait_any(cyc, i_fin, d_fin);
        check("fair_i_next", {i_fin, d_fin}, 2'b10);
        check("fair_i_cycle", cyc, 4);
        I_READ = 1'b0;
        wait_any(cyc, i_fin, d_fin);
        check("fair_d_after", {i_fin, d_fin}, 2'b01);
        check("fair_d_data", D_READDATA, model_read(28'h0500005));
        D_READ = 1'b0;
        @(negedge CLK);

        // Reset during GRANT_D
        do_reset();
        lat_cfg = 4;
        D_ADDRESS = 28'h0500006; D_READ = 1'b1;
        @(negedge CLK);
        check("rstmid_granted", MEM_READ, 1'b1);
        #2 RESET = 1'b0;
        #1;
        check("rstmid_read_drops", MEM_READ, 1'b0);
        check("rstmid_write_low", MEM_WRITE, 1'b0);
        check("rstmid_addr_cleared", MEM_ADDRESS, 28'h0);
        check("rstmid_d_busy", D_BUSYWAIT, 1'b1);
        @(negedge CLK);
        check("rstmid_no_done", D_BUSYWAIT, 1'b1);
        check("rstmid_read_held_low", MEM_READ, 1'b0);
        RESET = 1'b1;
        cyc2 = 0;
        do begin
            @(negedge CLK);
            cyc2++;
        end while (D_BUSYWAIT && cyc2 < 60);
        check("rstmid_regrant_cycle", cyc2, 6);
        check("rstmid_data", D_READDATA, model_read(28'h0500006));
        D_READ = 1'b0;
        @(negedge CLK);

        // Randomized run against the transaction-level model
        begin
            bit   prev_valid = 1'b0;
            bit   prev_who_d = 1'b0;
            bit   prev_other_wait = 1'b0;
            int   prev_c = 0;
            int   n_i = 0;
            int   n_d = 0;
            bit   i_done, d_done;
            do_reset();
            rand_lat = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                @(negedge CLK);
                i_done = I_READ && !I_BUSYWAIT;
                d_done = (D_READ || D_WRITE) && !D_BUSYWAIT;
                if (i_done || d_done) check("rand_one_outstanding", i_done && d_done, 1'b0);
                if (i_done) begin
                    n_i++;
                    check("rand_i_data", I_READDATA, model_read(I_ADDRESS));
                    if (prev_valid && prev_other_wait) begin
                        check("rand_fair_i", prev_who_d, 1'b1);
                        check("rand_latency_i", c - prev_c, 2 + max2(2, cur_lat + 1));
                    end
                    prev_valid = 1'b1; prev_who_d = 1'b0; prev_c = c;
                    prev_other_wait = D_READ || D_WRITE;
                end
                if (d_done) begin
                    n_d++;
                    if (D_WRITE) ref_mem[D_ADDRESS] = D_WRITEDATA;
                    else         check("rand_d_data", D_READDATA, model_read(D_ADDRESS));
                    if (prev_valid && prev_other_wait) begin
                        check("rand_fair_d", prev_who_d, 1'b0);
                        check("rand_latency_d", c - prev_c, 2 + max2(2, cur_lat + 1));
                    end
                    prev_valid = 1'b1; prev_who_d = 1'b1; prev_c = c;
                    prev_other_wait = I_READ;
                end
                if (i_done) begin
                    if ($urandom_range(0, 1) == 1) I_ADDRESS = 28'h1000000 | 28'($urandom_range(0, 65535));
                    else                           I_READ = 1'b0;
                end else if (!I_READ && $urandom_range(0, 3) == 0) begin
                    I_ADDRESS = 28'h1000000 | 28'($urandom_range(0, 65535));
                    I_READ = 1'b1;
                end
                if (d_done) begin
                    if ($urandom_range(0, 1) == 1) new_d_req();
                    else begin D_READ = 1'b0; D_WRITE = 1'b0; end
                end else if (!(D_READ || D_WRITE) && $urandom_range(0, 3) == 0) begin
                    new_d_req();
                end
            end
            check("rand_i_served", n_i > 20, 1'b1);
            check("rand_d_served", n_d > 20, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
